bcd_serial_add_ctrl: RTL and testbench
======================================

Name: bcd_serial_add_ctrl

Overview:
Digit-serial sequencer for a multi-digit packed-BCD add.
- Latches two DIGITS-wide packed-BCD operands on a START handshake.
- Steps one shared 4-bit BCD digit-adder stage across the digits, least significant first, one digit per clock, rippling the carry through a register.
- Presents the full result with a one-cycle DONE pulse.
- Sits between the register-file/bus interface and the BCD arithmetic datapath, so wide BCD adds reuse a single digit-adder stage.

Parameters:
DIGITS, 4, number of BCD digits per operand (legal 1..8); operand width is 4*DIGITS.

Ports:
CLK  input  1  rising-edge clock
RST_N  input  1  asynchronous active-low reset
START  input  1  request; sampled only when not BUSY
A  input  4*DIGITS  packed-BCD operand A, digit 0 in [3:0]
B  input  4*DIGITS  packed-BCD operand B
C_IN  input  1  carry into digit 0
BUSY  output  1  high while a sequence is in progress
DONE  output  1  one-cycle pulse: SUM/COUT/ERR valid
SUM  output  4*DIGITS  packed-BCD result, held between operations
COUT  output  1  carry out of the most significant digit
ERR  output  1  any operand digit > 9 in the completed operation

Behaviour:
- Interface fixed: one clock CLK; reset RST_N is asynchronous, active-low.
- Reset (RST_N low, async): FSM to IDLE. BUSY, DONE, COUT, ERR are 0. SUM, working registers, carry register and digit index are 0. Takes effect immediately, including mid-RUN. No DONE is produced for an aborted operation.
- FSM states: IDLE, RUN.
- IDLE:
  - START=1 at a clock edge latches A, B, C_IN into working registers.
  - Same edge: clears index to 0, clears the working ERR flag, moves to RUN, sets BUSY=1.
- RUN, each edge, processing digit i = index:
  - s = a_i + b_i + carry (carry is C_IN for i=0).
  - If s >= 10 then s = s + 6.
  - Working digit i = s[3:0]; carry = s[4].
  - Working ERR |= (a_i > 9) | (b_i > 9).
  - If i = DIGITS-1: copy working result to SUM, final carry to COUT, working ERR to ERR; set DONE=1 and BUSY=0; go to IDLE.
  - Otherwise index = index + 1.
- Latency: with START sampled at edge t0, DONE is high in the cycle following edge t0+DIGITS. Throughput is one operation per DIGITS+1 cycles when START is held high.
- SUM, COUT and ERR change only at the completing edge. They hold the previous result throughout BUSY.
- START while BUSY is ignored; operands are not re-latched.
- START high in the DONE cycle is accepted, because the FSM is already in IDLE. That is a back-to-back operation.
- DONE is registered and lasts exactly one cycle.
- Invalid digits (> 9) still pass through the correction rule above; the result digit is unspecified but deterministic. ERR=1 flags the condition.
- Max digit sum is 9+9+1 = 19, which yields digit 9, carry 1. No overflow beyond COUT.

Optional Feature:
Macro BCD_SUB_EN.
- Defined:
  - Adds input port SUB (1 bit), latched with the operands at START.
  - When SUB=1, each b_i is replaced by its nine's complement (9 - b_i), carry into digit 0 is forced to 1 and C_IN is ignored. Result is A - B in ten's-complement form.
  - COUT=1 means no borrow (A >= B). COUT=0 means negative, and SUM is the ten's complement of |A-B|.
  - ERR checks the original b_i, before complementing.
- Undefined: no SUB port; addition only.

Test Plan:
1. DIGITS=4, A=0x1234, B=0x5678, C_IN=0, pulse START -> BUSY high 4 cycles; DONE pulse; SUM=0x6912, COUT=0, ERR=0.
2. A=0x9999, B=0x0001, C_IN=0 -> SUM=0x0000, COUT=1. Then A=0x9999, B=0x9999, C_IN=1 -> SUM=0x9999, COUT=1.
3. START high again in the DONE cycle with A=0x0005, B=0x0005 -> accepted immediately; next DONE 5 cycles later, SUM=0x0010. START pulses with other operands during that BUSY -> ignored, result unchanged.
4. RST_N low 2 cycles into RUN -> BUSY, DONE, SUM, COUT, ERR all 0 asynchronously; no DONE after release until a new START.
5. A=0x12A4, B=0x0001 -> DONE with ERR=1. Next valid operation, A=0x0001, B=0x0001 -> ERR=0, SUM=0x0002.
6. (BCD_SUB_EN) SUB=1, A=0x0100, B=0x0001 -> SUM=0x0099, COUT=1. SUB=1, A=0x0001, B=0x0002 -> SUM=0x9999, COUT=0.

Source files
------------

// File: rtl/bcd_serial_add_ctrl_if.sv
// ---------------------------------------------------------------------------
// bcd_serial_add_ctrl_if
// Handshake and data bus for the digit-serial packed-BCD adder sequencer.
//   START        request, sampled by the sequencer only while idle
//   A, B         packed-BCD operands, digit 0 in [3:0]
//   C_IN         carry into digit 0
//   SUB          subtract select (only when BCD_SUB_EN is defined)
//   BUSY         sequence in progress
//   DONE         one-cycle pulse, SUM/COUT/ERR valid
//   SUM          packed-BCD result, held between operations
//   COUT         carry out of the most significant digit
//   ERR          an operand digit of the completed operation was > 9
// Modports: master drives requests/operands, slave (the sequencer) drives
// status and results.
// Optional feature macro: BCD_SUB_EN
// ---------------------------------------------------------------------------
interface bcd_serial_add_ctrl_if #(
    parameter int DIGITS = 4
);
    logic                  START;
    logic [4*DIGITS-1:0]   A;
    logic [4*DIGITS-1:0]   B;
    logic                  C_IN;
`ifdef BCD_SUB_EN
    logic                  SUB;
`endif
    logic                  BUSY;
    logic                  DONE;
    logic [4*DIGITS-1:0]   SUM;
    logic                  COUT;
    logic                  ERR;

    modport master (
        output START, A, B, C_IN,
`ifdef BCD_SUB_EN
        output SUB,
`endif
        input  BUSY, DONE, SUM, COUT, ERR
    );

    modport slave (
        input  START, A, B, C_IN,
`ifdef BCD_SUB_EN
        input  SUB,
`endif
        output BUSY, DONE, SUM, COUT, ERR
    );
endinterface

// File: rtl/bcd_serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// bcd_serial_add_ctrl
// Digit-serial sequencer for a multi-digit packed-BCD add. Operands are
// latched on START, then one shared 4-bit BCD digit adder is stepped across
// the digits (least significant first, one per clock) with the carry held in
// a register. The completed result is published with a one-cycle DONE.
// Ports:
//   CLK    rising-edge clock
//   RST_N  asynchronous active-low reset
//   bus    bcd_serial_add_ctrl_if.slave (START, A, B, C_IN, [SUB],
//          BUSY, DONE, SUM, COUT, ERR)
// Parameter: DIGITS (1..8) digits per operand.
// Optional feature macro: BCD_SUB_EN (adds SUB; A - B in ten's complement).
// ---------------------------------------------------------------------------
module bcd_serial_add_ctrl #(
    parameter int DIGITS = 4
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    bcd_serial_add_ctrl_if.slave   bus
);
    localparam int W     = 4 * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state_q, state_d;
    logic [W-1:0]       a_q, a_d;
    logic [W-1:0]       b_q, b_d;
    logic [W-1:0]       work_q, work_d;
    logic               carry_q, carry_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               werr_q, werr_d;
    logic [W-1:0]       sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               err_q, err_d;
    logic               done_q, done_d;
`ifdef BCD_SUB_EN
    logic               sub_q, sub_d;
`endif

    logic [IDX_W+1:0]   lsb;
    logic [3:0]         dig_a, dig_b, dig_b_eff;
    logic [4:0]         dsum;
    logic               dig_bad;

    // One BCD digit add: binary sum, +6 correction when >= 10.
    // Returns {carry, digit}; invalid digits give a deterministic result.
    function automatic logic [4:0] bcd_digit_add(input logic [3:0] x,
                                                 input logic [3:0] y,
                                                 input logic       c);
        logic [5:0] s;
        s = {2'b00, x} + {2'b00, y} + {5'b0, c};
        if (s >= 6'd10) s = s + 6'd6;
        return s[4:0];
    endfunction

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        work_d  = work_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        werr_d  = werr_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        err_d   = err_q;
        done_d  = 1'b0;
`ifdef BCD_SUB_EN
        sub_d   = sub_q;
`endif

        lsb     = {idx_q, 2'b00};
        dig_a   = a_q[lsb +: 4];
        dig_b   = b_q[lsb +: 4];
`ifdef BCD_SUB_EN
        // Nine's complement of B; error check still uses the original digit.
        dig_b_eff = sub_q ? (4'd9 - dig_b) : dig_b;
`else
        dig_b_eff = dig_b;
`endif
        dsum    = bcd_digit_add(dig_a, dig_b_eff, carry_q);
        dig_bad = (dig_a > 4'd9) | (dig_b > 4'd9);

        case (state_q)
            IDLE: begin
                if (bus.START) begin
                    a_d     = bus.A;
                    b_d     = bus.B;
                    work_d  = '0;
                    idx_d   = '0;
                    werr_d  = 1'b0;
`ifdef BCD_SUB_EN
                    sub_d   = bus.SUB;
                    // Ten's complement: +1 into digit 0 replaces C_IN.
                    carry_d = bus.SUB ? 1'b1 : bus.C_IN;
`else
                    carry_d = bus.C_IN;
`endif
                    state_d = RUN;
                end
            end
            RUN: begin
                work_d[lsb +: 4] = dsum[3:0];
                carry_d          = dsum[4];
                werr_d           = werr_q | dig_bad;
                if (idx_q == IDX_W'(DIGITS - 1)) begin
                    sum_d   = work_d;
                    cout_d  = dsum[4];
                    err_d   = werr_q | dig_bad;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            work_q  <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            werr_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
`ifdef BCD_SUB_EN
            sub_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            work_q  <= work_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            werr_q  <= werr_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            err_q   <= err_d;
            done_q  <= done_d;
`ifdef BCD_SUB_EN
            sub_q   <= sub_d;
`endif
        end
    end

    assign bus.BUSY = (state_q == RUN);
    assign bus.DONE = done_q;
    assign bus.SUM  = sum_q;
    assign bus.COUT = cout_q;
    assign bus.ERR  = err_q;
endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
module tb_bcd_serial_add_ctrl;
    localparam int DIGITS = 4;

    logic CLK;
    logic RST_N;
    int   errors;
    int   checks;

    bcd_serial_add_ctrl_if #(.DIGITS(DIGITS)) bus ();

    bcd_serial_add_ctrl #(.DIGITS(DIGITS)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Pulse START with the given operands, then wait (bounded) for DONE.
    // lat counts edges after the accepting edge until DONE is seen.
    task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                         input logic cin, output int lat,
                         output int busy_cnt, output bit to);
        @(negedge CLK);
        bus.A = a; bus.B = b; bus.C_IN = cin; bus.START = 1'b1;
        @(posedge CLK); #1;
        bus.START = 1'b0;
        lat = 0; busy_cnt = 0; to = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (bus.BUSY) busy_cnt++;
            if (bus.DONE) begin to = 1'b0; break; end
            @(posedge CLK); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        bus.START = 1'b0; bus.A = '0; bus.B = '0; bus.C_IN = 1'b0;
`ifdef BCD_SUB_EN
        bus.SUB = 1'b0;
`endif
        repeat (2) @(posedge CLK);
        #1;
        checks++; if (bus.BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.BUSY); end
        checks++; if (bus.DONE !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.DONE); end
        checks++; if (bus.SUM !== 16'h0000) begin errors++; $display("FAIL reset_sum: got %h want 0000", bus.SUM); end
        checks++; if (bus.COUT !== 1'b0) begin errors++; $display("FAIL reset_cout: got %b want 0", bus.COUT); end
        checks++; if (bus.ERR !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", bus.ERR); end
        @(negedge CLK);
        RST_N = 1'b1;
    endtask

    task automatic test_basic();
        int lat, bc; bit to;
        do_op(16'h1234, 16'h5678, 1'b0, lat, bc, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL basic_timeout: no DONE within bound"); end
        checks++; if (lat !== DIGITS) begin errors++; $display("FAIL basic_latency: got %0d want %0d", lat, DIGITS); end
        checks++; if (bc !== DIGITS) begin errors++; $display("FAIL basic_busy_cycles: got %0d want %0d", bc, DIGITS); end
        checks++; if (bus.SUM !== 16'h6912) begin errors++; $display("FAIL basic_sum: got %h want 6912", bus.SUM); end
        checks++; if (bus.COUT !== 1'b0) begin errors++; $display("FAIL basic_cout: got %b want 0", bus.COUT); end
        checks++; if (bus.ERR !== 1'b0) begin errors++; $display("FAIL basic_err: got %b want 0", bus.ERR); end
        @(posedge CLK); #1;
        checks++; if (bus.DONE !== 1'b0) begin errors++; $display("FAIL basic_done_width: got %b want 0", bus.DONE); end
    endtask

    task automatic test_carry();
        int lat, bc; bit to;
        do_op(16'h9999, 16'h0001, 1'b0, lat, bc, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL carry1_timeout: no DONE within bound"); end
        checks++; if (bus.SUM !== 16'h0000) begin errors++; $display("FAIL carry1_sum: got %h want 0000", bus.SUM); end
        checks++; if (bus.COUT !== 1'b1) begin errors++; $display("FAIL carry1_cout: got %b want 1", bus.COUT); end
        do_op(16'h9999, 16'h9999, 1'b1, lat, bc, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL carry2_timeout: no DONE within bound"); end
        checks++; if (bus.SUM !== 16'h9999) begin errors++; $display("FAIL carry2_sum: got %h want 9999", bus.SUM); end
        checks++; if (bus.COUT !== 1'b1) begin errors++; $display("FAIL carry2_cout: got %b want 1", bus.COUT); end
    endtask

    task automatic test_reset_abort();
        int dones;
        @(negedge CLK);
        bus.A = 16'h1234; bus.B = 16'h1111; bus.C_IN = 1'b0; bus.START = 1'b1;
        @(posedge CLK); #1;
        bus.START = 1'b0;
        @(posedge CLK); #3;
        RST_N = 1'b0;
        #1;
        checks++; if (bus.BUSY !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", bus.BUSY); end
        checks++; if (bus.DONE !== 1'b0) begin errors++; $display("FAIL abort_done: got %b want 0", bus.DONE); end
        checks++; if (bus.SUM !== 16'h0000) begin errors++; $display("FAIL abort_sum: got %h want 0000", bus.SUM); end
        checks++; if (bus.COUT !== 1'b0) begin errors++; $display("FAIL abort_cout: got %b want 0", bus.COUT); end
        checks++; if (bus.ERR !== 1'b0) begin errors++; $display("FAIL abort_err: got %b want 0", bus.ERR); end
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge CLK); #1;
            if (bus.DONE || bus.BUSY) dones++;
        end
        checks++; if (dones !== 0) begin errors++; $display("FAIL abort_no_done: got %0d active cycles want 0", dones); end
    endtask

    task automatic test_back_to_back();
        int lat, bc, gap; bit to, got, held_ok; int extra;
        do_op(16'h0010, 16'h0020, 1'b0, lat, bc, to);
        checks++; if (bus.SUM !== 16'h0030) begin errors++; $display("FAIL b2b_first_sum: got %h want 0030", bus.SUM); end
        // Still inside the DONE cycle: request the next operation now.
        bus.A = 16'h0005; bus.B = 16'h0005; bus.C_IN = 1'b0; bus.START = 1'b1;
        @(posedge CLK); #1;
        bus.START = 1'b0;
        checks++; if (bus.BUSY !== 1'b1) begin errors++; $display("FAIL b2b_accept: busy got %b want 1", bus.BUSY); end
        gap = 1; got = 1'b0; held_ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (bus.DONE) begin got = 1'b1; break; end
            if (bus.BUSY && bus.SUM !== 16'h0030) held_ok = 1'b0;
            bus.START = (i == 1 || i == 2);
            if (i == 1) begin bus.A = 16'h1111; bus.B = 16'h2222; end
            @(posedge CLK); #1;
            gap++;
        end
        bus.START = 1'b0;
        checks++; if (got !== 1'b1) begin errors++; $display("FAIL b2b_timeout: no second DONE within bound"); end
        checks++; if (gap !== DIGITS + 1) begin errors++; $display("FAIL b2b_gap: got %0d want %0d", gap, DIGITS + 1); end
        checks++; if (held_ok !== 1'b1) begin errors++; $display("FAIL b2b_sum_held: SUM changed while busy, want 0030"); end
        checks++; if (bus.SUM !== 16'h0010) begin errors++; $display("FAIL b2b_sum: got %h want 0010", bus.SUM); end
        checks++; if (bus.COUT !== 1'b0) begin errors++; $display("FAIL b2b_cout: got %b want 0", bus.COUT); end
        extra = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge CLK); #1;
            if (bus.DONE || bus.BUSY) extra++;
        end
        checks++; if (extra !== 0) begin errors++; $display("FAIL b2b_ignored_start: got %0d active cycles want 0", extra); end
    endtask

    task automatic test_err();
        int lat, bc; bit to;
        do_op(16'h12A4, 16'h0001, 1'b0, lat, bc, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL err_timeout: no DONE within bound"); end
        checks++; if (bus.ERR !== 1'b1) begin errors++; $display("FAIL err_flag: got %b want 1", bus.ERR); end
        checks++; if (bus.SUM !== 16'h1305) begin errors++; $display("FAIL err_sum: got %h want 1305", bus.SUM); end
        do_op(16'h0001, 16'h0001, 1'b0, lat, bc, to);
        checks++; if (bus.ERR !== 1'b0) begin errors++; $display("FAIL err_clear: got %b want 0", bus.ERR); end
        checks++; if (bus.SUM !== 16'h0002) begin errors++; $display("FAIL err_next_sum: got %h want 0002", bus.SUM); end
    endtask

`ifdef BCD_SUB_EN
    task automatic test_sub();
        int lat, bc; bit to;
        bus.SUB = 1'b1;
        do_op(16'h0100, 16'h0001, 1'b0, lat, bc, to);
        checks++; if (bus.SUM !== 16'h0099) begin errors++; $display("FAIL sub1_sum: got %h want 0099", bus.SUM); end
        checks++; if (bus.COUT !== 1'b1) begin errors++; $display("FAIL sub1_cout: got %b want 1", bus.COUT); end
        do_op(16'h0001, 16'h0002, 1'b0, lat, bc, to);
        checks++; if (bus.SUM !== 16'h9999) begin errors++; $display("FAIL sub2_sum: got %h want 9999", bus.SUM); end
        checks++; if (bus.COUT !== 1'b0) begin errors++; $display("FAIL sub2_cout: got %b want 0", bus.COUT); end
        bus.SUB = 1'b0;
    endtask
`endif

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_basic();
        test_carry();
        test_reset_abort();
        test_back_to_back();
        test_err();
`ifdef BCD_SUB_EN
        test_sub();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
